// File: rtl/score_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : score_mux_if
// Purpose  : Bundles the score inputs and display outputs of score_mux.
//            The master side (game logic / board model) drives digits and
//            observes the display pins. The slave side (score_mux) samples
//            digits and drives the display pins.
// Signals  : digits [4*NUM_DIGITS] packed BCD scores, digit k in [4k+3:4k]
//            seg    [7]            segments {g,f,e,d,c,b,a}, active-high
//            an     [NUM_DIGITS]   one-hot digit enable, active-high
//            frame  [1]            pulse at the first cycle of digit 0's slot
// Revision : 1.0 - initial release
// ============================================================================
interface score_mux_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame;

    modport master (output digits, input seg, input an, input frame);
    modport slave  (input digits, output seg, output an, output frame);
endinterface
`default_nettype wire

// File: rtl/score_mux.sv
`default_nettype none
// ============================================================================
// Module   : score_mux
// Purpose  : Time-multiplexed seven-segment driver for the score display.
//            Cycles through NUM_DIGITS BCD digits. Each digit owns a slot of
//            SLOT_CYCLES clocks, and the first DEAD_CYCLES of every slot are
//            blanked to stop ghosting. All outputs come from flops.
// Ports    : clk      system clock
//            reset_n  asynchronous active-low reset
//            bus      score_mux_if.slave (digits in; seg, an, frame out)
// Options  : SCORE_MUX_BLINK_EN - when defined, any digit >= WIN_SCORE
//            (game over) blanks the whole display while the MSB of a
//            free-running BLINK_WIDTH-bit counter is 0.
// Revision : 1.0 - initial release
// ============================================================================
module score_mux #(
    parameter int NUM_DIGITS  = 2,
    parameter int SLOT_CYCLES = 1,
    parameter int DEAD_CYCLES = 0,
    parameter int BLINK_WIDTH = 10,
    parameter int WIN_SCORE   = 9
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    score_mux_if.slave  bus
);
    localparam int SC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [SC_W-1:0]       sc;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            cur_val;
    logic [NUM_DIGITS-1:0] an_hot;
    logic                  dead;
    logic                  blink_off;
    logic                  blanked;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;   // non-BCD shows a dash
        endcase
        return s;
    endfunction

    // Slot counter and digit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc  <= '0;
            idx <= '0;
        end else if (sc == SC_LAST) begin
            sc  <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            sc  <= sc + 1'b1;
        end
    end

    // Select the current digit and build its enable. A compare loop keeps
    // indexing in range even when NUM_DIGITS is not a power of two.
    always_comb begin
        cur_val = 4'd0;
        an_hot  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_val   = bus.digits[4*k +: 4];
                an_hot[k] = 1'b1;
            end
        end
    end

    generate
        if (DEAD_CYCLES > 0) begin : g_dead
            assign dead = (sc < SC_W'(DEAD_CYCLES));
        end else begin : g_no_dead
            assign dead = 1'b0;
        end
    endgenerate

`ifdef SCORE_MUX_BLINK_EN
    logic [BLINK_WIDTH-1:0] bc;
    logic                   game_over;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bc <= '0;
        end else begin
            bc <= bc + BLINK_WIDTH'(1);
        end
    end

    always_comb begin
        game_over = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(bus.digits[4*k +: 4]) >= WIN_SCORE) begin
                game_over = 1'b1;
            end
        end
    end

    // Off half of the blink period: the MSB low blanks the display
    assign blink_off = game_over & ~bc[BLINK_WIDTH-1];
`else
    assign blink_off = 1'b0;
`endif

    assign blanked = dead | blink_off;

    // Output registers. The frame pulse ignores blanking so that the refresh
    // timing stays visible during dead time and blinking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q   <= '0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            if (blanked) begin
                seg_q <= '0;
                an_q  <= '0;
            end else begin
                seg_q <= seg_decode(cur_val);
                an_q  <= an_hot;
            end
            frame_q <= (sc == '0) && (idx == '0);
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;
endmodule
`default_nettype wire

// File: tb/tb_score_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_mux
// Purpose  : Directed self-checking bench for score_mux. It drives three
//            instances: defaults (2 digits), a 4-digit instance with
//            dead time, and a 2-digit instance with BLINK_WIDTH=4. The
//            blink expectations follow SCORE_MUX_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_mux;
    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    score_mux_if #(.NUM_DIGITS(2)) ifa ();
    score_mux_if #(.NUM_DIGITS(4)) ifb ();
    score_mux_if #(.NUM_DIGITS(2)) ifc ();

    score_mux #(.NUM_DIGITS(2), .SLOT_CYCLES(1), .DEAD_CYCLES(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    score_mux #(.NUM_DIGITS(4), .SLOT_CYCLES(4), .DEAD_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));
    score_mux #(.NUM_DIGITS(2), .SLOT_CYCLES(1), .DEAD_CYCLES(0),
                .BLINK_WIDTH(4), .WIN_SCORE(9)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(ifc));

    // Segment patterns of digits 3,2,1,0 of 16'h0123, indexed by slot
    logic [6:0] seg_b [4] = '{7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge. Sampling happens on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic       blank_c;
        logic [1:0] exp_an2;
        logic [6:0] exp_seg;
        logic [3:0] exp_an4;
        int         c;

        reset_n    = 1'b0;
        ifa.digits = 8'h37;
        ifb.digits = 16'h0123;
        ifc.digits = 8'h95;
        repeat (3) @(negedge clk);

        check("rst_a_seg",   32'(ifa.seg),   32'h0);
        check("rst_a_an",    32'(ifa.an),    32'h0);
        check("rst_a_frame", 32'(ifa.frame), 32'h0);
        check("rst_b_an",    32'(ifb.an),    32'h0);

        // Defaults, 8'h37: digit 0 = 7, digit 1 = 3, alternating each cycle
        reset_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            if ((n % 2) == 1) begin
                check($sformatf("a37_an n=%0d", n),    32'(ifa.an),    32'h1);
                check($sformatf("a37_seg n=%0d", n),   32'(ifa.seg),   32'(7'b0000111));
                check($sformatf("a37_frame n=%0d", n), 32'(ifa.frame), 32'h1);
            end else begin
                check($sformatf("a37_an n=%0d", n),    32'(ifa.an),    32'h2);
                check($sformatf("a37_seg n=%0d", n),   32'(ifa.seg),   32'(7'b1001111));
                check($sformatf("a37_frame n=%0d", n), 32'(ifa.frame), 32'h0);
            end
        end

        // Change of digit 0 shows up on the next edge that selects it
        ifa.digits = 8'h32;
        step();
        check("a_chg_an",  32'(ifa.an),  32'h1);
        check("a_chg_seg", 32'(ifa.seg), 32'(7'b1011011));
        step();
        check("a_mid_an", 32'(ifa.an), 32'h2);

        // Asynchronous reset between clock edges while an = 10
        #1 reset_n = 1'b0;
        #1;
        check("arst_seg",   32'(ifa.seg),   32'h0);
        check("arst_an",    32'(ifa.an),    32'h0);
        check("arst_frame", 32'(ifa.frame), 32'h0);

        // Invalid digit 8'h0F: digit 0 dash, digit 1 zero
        @(negedge clk);
        ifa.digits = 8'h0F;
        reset_n    = 1'b1;
        step();
        check("a0f_an0",    32'(ifa.an),    32'h1);
        check("a0f_seg0",   32'(ifa.seg),   32'(7'b1000000));
        check("a0f_frame0", 32'(ifa.frame), 32'h1);
        step();
        check("a0f_an1",    32'(ifa.an),    32'h2);
        check("a0f_seg1",   32'(ifa.seg),   32'(7'b0111111));
        check("a0f_frame1", 32'(ifa.frame), 32'h0);

        // Fresh run: 4-digit dead-time instance and the blink instance
        restart();
        for (int n = 1; n <= 64; n++) begin
            step();
            c = n - 1;
            if ((c % 4) == 0) begin
                exp_an4 = 4'b0000;
                exp_seg = 7'b0;
            end else begin
                exp_an4 = 4'b0001 << ((c / 4) % 4);
                exp_seg = seg_b[(c / 4) % 4];
            end
            check($sformatf("b_an n=%0d", n),    32'(ifb.an),    32'(exp_an4));
            check($sformatf("b_seg n=%0d", n),   32'(ifb.seg),   32'(exp_seg));
            check($sformatf("b_frame n=%0d", n), 32'(ifb.frame), ((c % 16) == 0) ? 32'h1 : 32'h0);

`ifdef SCORE_MUX_BLINK_EN
            blank_c = (((c / 8) % 2) == 0);
`else
            blank_c = 1'b0;
`endif
            if (blank_c) begin
                exp_an2 = 2'b00;
                exp_seg = 7'b0;
            end else if ((c % 2) == 0) begin
                exp_an2 = 2'b01;
                exp_seg = 7'b1101101;
            end else begin
                exp_an2 = 2'b10;
                exp_seg = 7'b1101111;
            end
            check($sformatf("c95_an n=%0d", n),    32'(ifc.an),    32'(exp_an2));
            check($sformatf("c95_seg n=%0d", n),   32'(ifc.seg),   32'(exp_seg));
            check($sformatf("c95_frame n=%0d", n), 32'(ifc.frame), ((c % 2) == 0) ? 32'h1 : 32'h0);
        end

        // 8'h85: no digit reaches WIN_SCORE, so no blanking in either build
        ifc.digits = 8'h85;
        restart();
        for (int n = 1; n <= 16; n++) begin
            step();
            if ((n % 2) == 1) begin
                check($sformatf("c85_an n=%0d", n),  32'(ifc.an),  32'h1);
                check($sformatf("c85_seg n=%0d", n), 32'(ifc.seg), 32'(7'b1101101));
            end else begin
                check($sformatf("c85_an n=%0d", n),  32'(ifc.an),  32'h2);
                check($sformatf("c85_seg n=%0d", n), 32'(ifc.seg), 32'(7'b1111111));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
